// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative restoring divider for RISC-V DIV/DIVU/REM/REMU
//
// add_sub : W-bit adder/subtractor (sum = a + b, or a - b when sub=1)
// div_unit: one quotient bit per cycle, fixed N+2 cycle latency from accept
//   clk, reset            rising-edge clock, synchronous active-high reset
//   start, is_signed      request (taken only when idle), signed-mode select
//   dividend, divisor     operands, captured on accept
//   flush                 abandon the operation in flight without a result
//   busy                  operation in flight (RUN or FINISH)
//   valid                 one-cycle result strobe
//   quotient, remainder   registered results, held until the next valid

module add_sub #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic [W-1:0] sum
);
    logic [W-1:0] b_eff;

    always_comb begin
        b_eff = sub ? ~b : b;
        sum   = a + b_eff + {{(W-1){1'b0}}, sub};
    end
endmodule

module div_unit #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         is_signed,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    input  logic         flush,
    output logic         busy,
    output logic         valid,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder
);
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FINISH
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  rem_q, rem_d;
    logic [N-1:0]  quo_q, quo_d;        // dividend bits shift out, quotient bits shift in
    logic [N-1:0]  dvs_q, dvs_d;
    logic [N-1:0]  orig_q, orig_d;      // raw dividend, returned as remainder on divide-by-zero
    logic          dvd_neg_q, dvd_neg_d;
    logic          dvs_neg_q, dvs_neg_d;
    logic [N-1:0]  quotient_q, quotient_d;
    logic [N-1:0]  remainder_q, remainder_d;
    logic          valid_q, valid_d;

    logic [N:0]    rem_shift;
    logic [N:0]    trial;
    logic          borrow;
    logic          a_neg, b_neg;
    logic [N-1:0]  a_abs, b_abs;

    assign rem_shift = {rem_q, quo_q[N-1]};

    add_sub #(.W(N + 1)) u_trial (
        .a   (rem_shift),
        .b   ({1'b0, dvs_q}),
        .sub (1'b1),
        .sum (trial)
    );

    // rem_shift < 2*divisor, so a non-negative difference is below 2^N and a
    // negative one wraps to at least 2^N: the top bit alone marks the borrow.
    assign borrow = trial[N];

    assign busy      = (state_q != S_IDLE);
    assign valid     = valid_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;

    always_comb begin
        a_neg = is_signed & dividend[N-1];
        b_neg = is_signed & divisor[N-1];
        a_abs = a_neg ? (~dividend + 1'b1) : dividend;
        b_abs = b_neg ? (~divisor + 1'b1) : divisor;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        orig_d      = orig_q;
        dvd_neg_d   = dvd_neg_q;
        dvs_neg_d   = dvs_neg_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        valid_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    dvd_neg_d = a_neg;
                    dvs_neg_d = b_neg;
                    quo_d     = a_abs;
                    dvs_d     = b_abs;
                    orig_d    = dividend;
                    rem_d     = '0;
                    cnt_d     = CW'(N - 1);
                    state_d   = S_RUN;
                end
            end
            S_RUN: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    rem_d = borrow ? rem_shift[N-1:0] : trial[N-1:0];
                    quo_d = {quo_q[N-2:0], ~borrow};
                    if (cnt_q == '0) begin
                        state_d = S_FINISH;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
                if (!flush) begin
                    valid_d = 1'b1;
                    if (dvs_q == '0) begin
                        quotient_d  = '1;
                        remainder_d = orig_q;
                    end else begin
                        quotient_d  = (dvd_neg_q ^ dvs_neg_q) ? (~quo_q + 1'b1) : quo_q;
                        remainder_d = dvd_neg_q ? (~rem_q + 1'b1) : rem_q;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            orig_q      <= '0;
            dvd_neg_q   <= 1'b0;
            dvs_neg_q   <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            orig_q      <= orig_d;
            dvd_neg_q   <= dvd_neg_d;
            dvs_neg_q   <= dvs_neg_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            valid_q     <= valid_d;
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - directed self-checking bench for div_unit (N=32)

module tb_div_unit;
    localparam int N = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         is_signed;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         flush;
    logic         busy;
    logic         valid;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;

    int checks = 0;
    int errors = 0;

    div_unit #(.N(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .flush     (flush),
        .busy      (busy),
        .valid     (valid),
        .quotient  (quotient),
        .remainder (remainder)
    );

    always #5 clk = ~clk;

    // Issues one request and steps until valid. Returns the cycle index of the
    // valid cycle (accept cycle = 0), the number of busy cycles and a timeout flag.
    task automatic do_op(input logic sgn, input logic [N-1:0] a, input logic [N-1:0] b,
                         output int lat, output int busy_cnt, output logic to);
        is_signed = sgn;
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        lat      = 1;
        busy_cnt = 0;
        while (!valid && lat < 200) begin
            if (busy) busy_cnt++;
            @(posedge clk); #1;
            lat++;
        end
        to = !valid;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start = 1'b1;
        flush = 1'b1;
        is_signed = 1'b0;
        dividend = 32'd9;
        divisor = 32'd3;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", valid); end
        checks++; if (quotient !== 32'h0) begin errors++; $display("FAIL reset_quotient got %h want 0", quotient); end
        checks++; if (remainder !== 32'h0) begin errors++; $display("FAIL reset_remainder got %h want 0", remainder); end
        start = 1'b0;
        flush = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_unsigned;
        int lat, bc;
        logic to;
        do_op(1'b0, 32'd100, 32'd7, lat, bc, to);
        checks++; if (to) begin errors++; $display("FAIL divu_timeout got no valid want valid"); end
        checks++; if (quotient !== 32'd14) begin errors++; $display("FAIL divu_q got %h want %h", quotient, 32'd14); end
        checks++; if (remainder !== 32'd2) begin errors++; $display("FAIL divu_r got %h want %h", remainder, 32'd2); end
        checks++; if (lat !== 34) begin errors++; $display("FAIL divu_latency got %0d want 34", lat); end
        checks++; if (bc !== 33) begin errors++; $display("FAIL divu_busy_cycles got %0d want 33", bc); end
        @(posedge clk); #1;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL valid_pulse got %0b want 0", valid); end
        do_op(1'b0, 32'hFFFFFFFF, 32'd1, lat, bc, to);
        checks++; if (quotient !== 32'hFFFFFFFF || remainder !== 32'h0) begin errors++; $display("FAIL divu_max got %h/%h want ffffffff/0", quotient, remainder); end
    endtask

    task automatic test_signed;
        int lat, bc;
        logic to;
        do_op(1'b1, 32'hFFFFFFF9, 32'd2, lat, bc, to);
        checks++; if (quotient !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_m7_2_q got %h want fffffffd", quotient); end
        checks++; if (remainder !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_m7_2_r got %h want ffffffff", remainder); end
        do_op(1'b1, 32'd7, 32'hFFFFFFFE, lat, bc, to);
        checks++; if (quotient !== 32'hFFFFFFFD || remainder !== 32'd1) begin errors++; $display("FAIL div_7_m2 got %h/%h want fffffffd/1", quotient, remainder); end
        do_op(1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, lat, bc, to);
        checks++; if (quotient !== 32'd3 || remainder !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_m7_m2 got %h/%h want 3/ffffffff", quotient, remainder); end
        checks++; if (lat !== 34) begin errors++; $display("FAIL div_signed_latency got %0d want 34", lat); end
    endtask

    task automatic test_div_zero;
        int lat, bc;
        logic to;
        do_op(1'b0, 32'h12345678, 32'h0, lat, bc, to);
        checks++; if (quotient !== 32'hFFFFFFFF || remainder !== 32'h12345678) begin errors++; $display("FAIL divz_unsigned got %h/%h want ffffffff/12345678", quotient, remainder); end
        checks++; if (lat !== 34) begin errors++; $display("FAIL divz_latency got %0d want 34", lat); end
        do_op(1'b1, 32'h12345678, 32'h0, lat, bc, to);
        checks++; if (quotient !== 32'hFFFFFFFF || remainder !== 32'h12345678) begin errors++; $display("FAIL divz_signed got %h/%h want ffffffff/12345678", quotient, remainder); end
        do_op(1'b1, 32'hFFFFFFFB, 32'h0, lat, bc, to);
        checks++; if (quotient !== 32'hFFFFFFFF || remainder !== 32'hFFFFFFFB) begin errors++; $display("FAIL divz_m5 got %h/%h want ffffffff/fffffffb", quotient, remainder); end
    endtask

    task automatic test_overflow;
        int lat, bc;
        logic to;
        do_op(1'b1, 32'h80000000, 32'hFFFFFFFF, lat, bc, to);
        checks++; if (quotient !== 32'h80000000 || remainder !== 32'h0) begin errors++; $display("FAIL ovf_signed got %h/%h want 80000000/0", quotient, remainder); end
        do_op(1'b0, 32'h80000000, 32'hFFFFFFFF, lat, bc, to);
        checks++; if (quotient !== 32'h0 || remainder !== 32'h80000000) begin errors++; $display("FAIL ovf_unsigned got %h/%h want 0/80000000", quotient, remainder); end
    endtask

    task automatic test_handshake;
        int lat;
        logic to;
        // extra starts and operand changes while busy
        is_signed = 1'b0;
        dividend  = 32'd1000;
        divisor   = 32'd10;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat   = 1;
        while (!valid && lat < 200) begin
            if (lat == 3 || lat == 4) begin
                start = 1'b1;
                is_signed = 1'b1;
                dividend = 32'd5;
                divisor = 32'd1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        checks++; if (lat !== 34) begin errors++; $display("FAIL hs_latency got %0d want 34", lat); end
        checks++; if (quotient !== 32'd100 || remainder !== 32'd0) begin errors++; $display("FAIL hs_result got %h/%h want 64/0", quotient, remainder); end
        @(posedge clk); #1;
        // flush at RUN cycle 10
        is_signed = 1'b0;
        dividend  = 32'd500;
        divisor   = 32'd3;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy got %0b want 0", busy); end
        checks++; if (valid !== 1'b0 || quotient !== 32'd100 || remainder !== 32'd0) begin errors++; $display("FAIL flush_hold got v=%0b %h/%h want v=0 64/0", valid, quotient, remainder); end
        // immediate restart; a stray valid from the flushed op would shorten lat
        do_op(1'b0, 32'd77, 32'd5, lat, lat, to);
        begin
            int l2, bc2;
            logic to2;
            l2 = 0;
            checks++; if (quotient !== 32'd15 || remainder !== 32'd2) begin errors++; $display("FAIL after_flush got %h/%h want f/2", quotient, remainder); end
            // flush together with start in IDLE must not accept
            is_signed = 1'b0; dividend = 32'd9; divisor = 32'd3;
            start = 1'b1; flush = 1'b1;
            @(posedge clk); #1;
            start = 1'b0; flush = 1'b0;
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_start_idle got busy=%0b want 0", busy); end
            do_op(1'b0, 32'd9, 32'd3, l2, bc2, to2);
            checks++; if (l2 !== 34 || to2) begin errors++; $display("FAIL restart_latency got %0d want 34", l2); end
        end
    endtask

    task automatic test_back_to_back;
        int lat, bc;
        logic to;
        do_op(1'b0, 32'd100, 32'd7, lat, bc, to);
        checks++; if (valid !== 1'b1 || quotient !== 32'd14) begin errors++; $display("FAIL b2b_first got v=%0b q=%h want v=1 q=e", valid, quotient); end
        // start during the valid cycle
        is_signed = 1'b1;
        dividend  = 32'h80000000;
        divisor   = 32'd3;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat   = 1;
        while (!valid && lat < 200) begin
            if (lat == 5) begin
                checks++; if (quotient !== 32'd14 || remainder !== 32'd2 || busy !== 1'b1) begin errors++; $display("FAIL b2b_held got %h/%h busy=%0b want e/2 busy=1", quotient, remainder, busy); end
            end
            @(posedge clk); #1;
            lat++;
        end
        checks++; if (lat !== 34) begin errors++; $display("FAIL b2b_latency got %0d want 34", lat); end
        checks++; if (quotient !== 32'hD5555556 || remainder !== 32'hFFFFFFFE) begin errors++; $display("FAIL b2b_second got %h/%h want d5555556/fffffffe", quotient, remainder); end
    endtask

    task automatic test_reset_mid_run;
        int seen;
        is_signed = 1'b0;
        dividend  = 32'd1234;
        divisor   = 32'd10;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++; if (busy !== 1'b0 || valid !== 1'b0) begin errors++; $display("FAIL rst_mid_ctrl got busy=%0b valid=%0b want 0/0", busy, valid); end
        checks++; if (quotient !== 32'h0 || remainder !== 32'h0) begin errors++; $display("FAIL rst_mid_out got %h/%h want 0/0", quotient, remainder); end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (valid) seen++;
            @(posedge clk); #1;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL rst_mid_novalid got %0d pulses want 0", seen); end
    endtask

    initial begin
        start = 1'b0;
        flush = 1'b0;
        test_reset;
        test_unsigned;
        test_signed;
        test_div_zero;
        test_overflow;
        test_handshake;
        test_back_to_back;
        test_reset_mid_run;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle iterative restoring divider; inverse operation of the ALU adder/multiplier path.
- Serves RISC-V M-extension DIV, DIVU, REM, REMU in the EX stage.
- Produces one quotient bit per cycle, with a start/busy/valid handshake toward the pipeline control.
- Trial subtraction uses the existing add_sub module, instantiated N+1 bits wide with sub=1.

Parameters:
- N, 32, operand/result width in bits; must be >= 2.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; accepted only when busy=0
- is_signed  input  1  1 selects DIV/REM (two's complement); 0 selects DIVU/REMU
- dividend  input  N  numerator; sampled only on accept
- divisor  input  N  denominator; sampled only on accept
- flush  input  1  abort the operation in flight; no result is produced
- busy  output  1  high from the cycle after accept until the result cycle
- valid  output  1  one-cycle pulse; quotient/remainder are valid in this cycle
- quotient  output  N  registered quotient; held until the next valid
- remainder  output  N  registered remainder; held until the next valid

Behaviour:
- Reset: state=IDLE; busy=0, valid=0, quotient=0, remainder=0; iteration counter=0. Reset overrides start and flush in the same cycle.
- States: IDLE, RUN, FINISH.
- IDLE, start=1 at edge E0:
  - Latch the operand signs.
  - Load |dividend| and |divisor| when is_signed=1, otherwise the raw values.
  - Partial remainder=0; counter=N-1; next state RUN; busy=1 from E0.
- RUN, each edge:
  - Shift {rem,quo} left by 1, bringing in the dividend MSB.
  - Trial = rem_shifted − divisor, computed (N+1)-bit.
  - If no borrow, rem=trial and quotient bit=1; else keep rem, bit=0.
  - Counter decrements. After the iteration where counter=0, next state FINISH. RUN lasts exactly N cycles.
- FINISH, one edge:
  - Divisor=0: quotient=all ones, remainder=original dividend (signed and unsigned).
  - Else, signed: negate the quotient if the operand signs differ; the remainder takes the sign of the dividend.
  - Else, unsigned: raw results.
  - Register quotient/remainder, valid=1 for one cycle, busy=0, next state IDLE.
- Overflow (signed, dividend=most-negative, divisor=−1): no special case. Natural result is quotient=most-negative, remainder=0; the bench must confirm it.
- Fixed latency: start accepted at E0 gives valid high in the cycle after edge E0+N+1, i.e. N+2 cycles after accept, for all operand values.
- Back-to-back:
  - start is accepted in the same cycle valid=1, since state is IDLE.
  - The new operation does not disturb the held outputs until its own FINISH.
- start while busy=1: ignored; no queuing.
- Operand changes while busy: no effect; operands are captured on accept only.
- flush=1 in RUN or FINISH:
  - Next state IDLE, busy=0, valid stays 0.
  - quotient/remainder keep their previous values.
  - flush has priority over the FINISH update.
- flush=1 together with start in IDLE: start is not accepted.
- Width rule: the most-negative dividend has |x|=2^(N−1), representable unsigned in N bits; the internal partial remainder is N+1 bits.

Test Plan:
- Unsigned: DIVU 100/7, is_signed=0.
  - quotient=14, remainder=2.
  - valid exactly 34 cycles after accept (N=32); busy high 33 cycles.
- Signed mixed signs: dividend=−7 (0xFFFFFFF9), divisor=2, is_signed=1.
  - quotient=0xFFFFFFFD (−3), remainder=0xFFFFFFFF (−1).
- Divide by zero:
  - dividend=0x12345678, divisor=0, both modes: quotient=0xFFFFFFFF, remainder=0x12345678.
  - Signed −5/0: quotient=0xFFFFFFFF, remainder=0xFFFFFFFB.
- Overflow: dividend=0x80000000, divisor=0xFFFFFFFF, signed.
  - quotient=0x80000000, remainder=0.
  - Unsigned, same operands: quotient=0, remainder=0x80000000.
- Handshake: start pulses during busy, with operand changes mid-RUN; then flush at RUN cycle 10.
  - Extra starts are ignored; result matches the original operands.
  - After flush, no valid pulse; outputs unchanged; busy=0 the next cycle.
  - A new start the cycle after flush completes normally.
- Back-to-back and reset:
  - start asserted in the valid cycle: second result arrives N+2 cycles later.
  - reset asserted mid-RUN: all outputs 0 and busy=0 on the next cycle; no valid.
